// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the execute stage and the HI/LO
// multiply/divide unit.
//
// Handshake: w_start is a request strobe with w_op_code_6/w_input1_x/
// w_input2_x as its payload. A request is taken at a rising clock edge
// only when w_busy is low in that cycle; while w_busy is high the
// requester sees w_stall and must hold the request unchanged until
// w_stall drops. w_done pulses for one cycle when HI/LO hold a new
// multiply/divide result.
//
// Signals:
//   w_start, w_op_code_6, w_input1_x, w_input2_x, w_hilo_read  requester -> unit
//   w_busy, w_done, w_stall, w_hi_x, w_lo_x                      unit -> requester
//   state_dbg                                                    unit FSM state (debug)
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             w_start;
  logic [5:0]       w_op_code_6;
  logic [WIDTH-1:0] w_input1_x;
  logic [WIDTH-1:0] w_input2_x;
  logic             w_hilo_read;
  logic             w_busy;
  logic             w_done;
  logic             w_stall;
  logic [WIDTH-1:0] w_hi_x;
  logic [WIDTH-1:0] w_lo_x;
  logic [1:0]       state_dbg;

  modport master (
    output w_start, w_op_code_6, w_input1_x, w_input2_x, w_hilo_read,
    input  w_busy, w_done, w_stall, w_hi_x, w_lo_x, state_dbg
  );

  modport slave (
    input  w_start, w_op_code_6, w_input1_x, w_input2_x, w_hilo_read,
    output w_busy, w_done, w_stall, w_hi_x, w_lo_x, state_dbg
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, each over
// WIDTH iterations plus one sign-fix cycle. MTHI/MTLO write HI/LO
// directly from idle. HI/LO are exported continuously.
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    hilo_muldiv_if slave modport (request, HI/LO, busy/done/stall,
//          FSM state debug)
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  hilo_muldiv_if.slave bus
);

  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam int         CW       = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]      cnt;
  // MUL: {partial product, remaining multiplier bits}.
  // DIV: {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand_b;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rs_orig;    // original rs, returned as HI on divide by zero
  logic               is_div;
  logic               div_zero;
  logic               neg_q;      // product / quotient sign
  logic               neg_r;      // remainder sign
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  // Request decode (only meaningful while idle)
  logic accept_mul, accept_div, accept_mthi, accept_mtlo;
  logic signed_op, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    accept_mul  = 1'b0;
    accept_div  = 1'b0;
    accept_mthi = 1'b0;
    accept_mtlo = 1'b0;
    if (state == S_IDLE && bus.w_start) begin
      case (bus.w_op_code_6)
        OP_MULT, OP_MULTU: accept_mul  = 1'b1;
        OP_DIV,  OP_DIVU:  accept_div  = 1'b1;
        OP_MTHI:           accept_mthi = 1'b1;
        OP_MTLO:           accept_mtlo = 1'b1;
        default: ;
      endcase
    end
  end

  assign signed_op = (bus.w_op_code_6 == OP_MULT) || (bus.w_op_code_6 == OP_DIV);
  assign sign_a    = signed_op & bus.w_input1_x[WIDTH-1];
  assign sign_b    = signed_op & bus.w_input2_x[WIDTH-1];
  assign mag_a     = sign_a ? -bus.w_input1_x : bus.w_input1_x;
  assign mag_b     = sign_b ? -bus.w_input2_x : bus.w_input2_x;

  logic last_iter;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept_mul)      state_next = S_MUL;
        else if (accept_div) state_next = S_DIV;
      end
      S_MUL:   if (last_iter) state_next = S_FIX;
      S_DIV:   if (last_iter) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One shift-add step: add multiplicand into the upper half when the
  // current multiplier LSB is set; the carry lands in the top bit after
  // the right shift.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);

  // One restoring step: the trial value is the remainder shifted left with
  // the next dividend bit; a clear top bit of the difference means the
  // divisor fits and the quotient bit is 1.
  logic [WIDTH:0] div_trial, div_diff;
  logic           div_ok;
  assign div_trial = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, operand_b};
  assign div_ok    = ~div_diff[WIDTH];

  // Sign fix-up for the FIX cycle
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = rs_orig;
        fix_lo = '1;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end
  end

  // Datapath and HI/LO
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      operand_b <= '0;
      rs_orig   <= '0;
      is_div    <= 1'b0;
      div_zero  <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_mthi) hi_q <= bus.w_input1_x;
          if (accept_mtlo) lo_q <= bus.w_input1_x;
          if (accept_mul || accept_div) begin
            cnt       <= '0;
            acc       <= {{WIDTH{1'b0}}, mag_a};
            operand_b <= mag_b;
            rs_orig   <= bus.w_input1_x;
            is_div    <= accept_div;
            div_zero  <= accept_div && (bus.w_input2_x == '0);
            neg_q     <= sign_a ^ sign_b;
            neg_r     <= sign_a;
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
        end
        S_DIV: begin
          acc <= {(div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ok};
          cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.w_busy    = (state != S_IDLE);
  assign bus.w_done    = done_q;
  assign bus.w_stall   = bus.w_busy & (bus.w_hilo_read | bus.w_start);
  assign bus.w_hi_x    = hi_q;
  assign bus.w_lo_x    = lo_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MFHI  = 6'h10;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  hilo_muldiv_if #(.WIDTH(32)) bus ();

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];          // {hi, lo} expected per mul/div
  logic [31:0] sh_hi, sh_lo;      // bench view of HI/LO
  int vectors    = 0;
  int miscompares = 0;
  int busy_cnt   = 0;
  bit prev_busy  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural values.
  function automatic logic [63:0] ref_model(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, r64, q64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      OP_MULT:  r64 = 64'(sa * sb);
      OP_MULTU: r64 = ua * ub;
      OP_DIV: begin
        if (b == 32'd0) r64 = {a, 32'hFFFFFFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          q64 = 64'(sq);
          r64 = 64'(sr);
          r64 = {r64[31:0], q64[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) r64 = {a, 32'hFFFFFFFF};
        else begin
          q64 = ua / ub;
          r64 = ua % ub;
          r64 = {r64[31:0], q64[31:0]};
        end
      end
      default: r64 = '0;
    endcase
    return r64;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      busy_cnt  = 0;
      prev_busy = 0;
    end else begin
      if (bus.w_busy) busy_cnt++;
      else if (prev_busy) begin
        check("busy_len", 64'(busy_cnt), 64'd33);
        busy_cnt = 0;
      end
      if (bus.w_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("result_hilo", {bus.w_hi_x, bus.w_lo_x}, e);
          sh_hi = e[63:32];
          sh_lo = e[31:0];
        end
      end
      prev_busy = bus.w_busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int guard = 0;
    while (bus.w_busy && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 200) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic settle();
    wait_idle();
    @(negedge clock);
    @(posedge clock); #1;
  endtask

  // Issue one request; returns one time unit after the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit use_exp, input logic [63:0] exp);
    wait_idle();
    bus.w_start     = 1'b1;
    bus.w_op_code_6 = op;
    bus.w_input1_x  = a;
    bus.w_input2_x  = b;
    @(posedge clock); #1;
    bus.w_start = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
        exp_q.push_back(use_exp ? exp : ref_model(op, a, b));
        check("busy_after_accept", 64'(bus.w_busy), 64'd1);
      end
      OP_MTHI: begin
        sh_hi = a;
        check("mthi_hi", 64'(bus.w_hi_x), 64'(a));
        check("mthi_flags", {62'd0, bus.w_busy, bus.w_done}, 64'd0);
      end
      OP_MTLO: begin
        sh_lo = a;
        check("mtlo_lo", 64'(bus.w_lo_x), 64'(a));
        check("mtlo_flags", {62'd0, bus.w_busy, bus.w_done}, 64'd0);
      end
      default: begin
        check("ignored_op_hilo", {bus.w_hi_x, bus.w_lo_x}, {sh_hi, sh_lo});
        check("ignored_op_busy", 64'(bus.w_busy), 64'd0);
      end
    endcase
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- global time bound ----------------
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0]  op;
    logic [31:0] a, b;
    reset           = 1'b1;
    bus.w_start     = 1'b0;
    bus.w_op_code_6 = 6'd0;
    bus.w_input1_x  = '0;
    bus.w_input2_x  = '0;
    bus.w_hilo_read = 1'b0;
    sh_hi = '0;
    sh_lo = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_hilo", {bus.w_hi_x, bus.w_lo_x}, 64'd0);
    check("reset_flags", {61'd0, bus.w_busy, bus.w_done, bus.w_stall}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed products and quotients
    issue(OP_MULT,  32'd7,        32'd6,        1, {32'h00000000, 32'h0000002A});
    issue(OP_MULT,  32'hFFFFFFFD, 32'd5,        1, {32'hFFFFFFFF, 32'hFFFFFFF1});
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, {32'hFFFFFFFE, 32'h00000001});
    issue(OP_DIV,   32'hFFFFFFF9, 32'd2,        1, {32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(OP_DIVU,  32'd100,      32'd7,        1, {32'd2, 32'd14});
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1, {32'h00000000, 32'h80000000});
    issue(OP_DIVU,  32'd100,      32'd0,        1, {32'h00000064, 32'hFFFFFFFF});
    issue(OP_DIV,   32'hFFFFFFF9, 32'd0,        1, {32'hFFFFFFF9, 32'hFFFFFFFF});
    settle();

    // Idle: MTHI, read-only and ignored opcode never stall
    issue(OP_MTHI, 32'h12345678, 32'd0, 0, 64'd0);
    bus.w_hilo_read = 1'b1;
    @(negedge clock);
    check("idle_read_stall", 64'(bus.w_stall), 64'd0);
    @(posedge clock); #1;
    bus.w_hilo_read = 1'b0;
    issue(OP_MFHI, 32'hCAFEF00D, 32'd0, 0, 64'd0);

    // Request held while busy: stalls, HI/LO frozen, MTLO not taken
    issue(OP_MTLO, 32'hA5A5A5A5, 32'd0, 0, 64'd0);
    issue(OP_MULT, 32'd7, 32'd6, 1, {32'h00000000, 32'h0000002A});
    repeat (4) begin @(posedge clock); #1; end
    bus.w_start     = 1'b1;
    bus.w_op_code_6 = OP_MTLO;
    bus.w_input1_x  = 32'hDEADBEEF;
    bus.w_hilo_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("busy_req_stall", 64'(bus.w_stall), 64'd1);
      check("busy_hilo_frozen", {bus.w_hi_x, bus.w_lo_x}, {sh_hi, sh_lo});
      @(posedge clock); #1;
    end
    bus.w_start = 1'b0;
    @(negedge clock);
    check("busy_read_stall", 64'(bus.w_stall), 64'd1);
    @(posedge clock); #1;
    bus.w_hilo_read = 1'b0;
    @(negedge clock);
    check("busy_no_req_stall", 64'(bus.w_stall), 64'd0);
    @(posedge clock); #1;
    settle();
    check("mtlo_dropped", 64'(bus.w_lo_x), 64'h2A);

    // Reset during a divide aborts it
    issue(OP_DIV, 32'h00001234, 32'd7, 0, 64'd0);
    repeat (9) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sh_hi = '0;
    sh_lo = '0;
    check("abort_hilo", {bus.w_hi_x, bus.w_lo_x}, 64'd0);
    check("abort_flags", {62'd0, bus.w_busy, bus.w_done}, 64'd0);
    repeat (40) @(posedge clock);
    #1;
    issue(OP_MULTU, 32'd3, 32'd4, 1, {32'd0, 32'd12});

    // Randomized mix, back to back
    for (int n = 0; n < 50; n++) begin
      case ($urandom_range(0, 7))
        0: op = OP_MULT;
        1: op = OP_MULTU;
        2: op = OP_DIV;
        3: op = OP_DIVU;
        4: op = OP_MTHI;
        5: op = OP_MTLO;
        6: op = OP_MFHI;
        default: op = 6'h00;
      endcase
      a = rand_operand();
      b = rand_operand();
      issue(op, a, b, 0, 64'd0);
    end
    settle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Sequential multiply/divide unit that owns the HI/LO register pair and is its only writer.
- Executes MULT, MULTU, DIV and DIVU iteratively (shift-add / restoring division) over WIDTH+1 cycles, and also executes MTHI and MTLO.
- HI/LO are exported continuously, so the execute stage serves MFHI/MFLO combinationally and stalls while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO register width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- w_start  input  1  request strobe; sampled only when w_busy=0.
- w_op_code_6  input  6  SPECIAL funct code:
  - MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B.
  - MTHI=0x11, MTLO=0x13, MFHI=0x10, MFLO=0x12.
- w_input1_x  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
- w_input2_x  input  WIDTH  rt operand (multiplier / divisor).
- w_hilo_read  input  1  consumer is executing MFHI or MFLO this cycle.
- w_busy  output  1  mult/div in progress.
- w_done  output  1  one-cycle pulse; HI/LO hold a new mult/div result.
- w_stall  output  1  equals w_busy & (w_hilo_read | w_start); combinational.
- w_hi_x  output  WIDTH  current HI register.
- w_lo_x  output  WIDTH  current LO register.

Behaviour:
- Reset:
  - State returns to IDLE.
  - HI=0, LO=0, w_busy=0, w_done=0; the iteration counter and working registers are cleared.
  - A reset asserted mid-operation aborts the operation; no partial result is written.
- State machine: IDLE, MUL, DIV, FIX.
- IDLE:
  - w_start=1 with MULT/MULTU: latch operands, go to MUL, w_busy=1 from the next cycle.
  - DIV/DIVU: latch operands, go to DIV.
  - MTHI: HI<=w_input1_x at the next edge; stay in IDLE; no w_busy, no w_done.
  - MTLO: LO<=w_input1_x at the next edge; same rules as MTHI.
  - MFHI/MFLO, or any other opcode with w_start: ignored, no state change.
- Signed ops (MULT, DIV):
  - At accept, operands are replaced by their magnitudes.
  - Result sign flags are recorded: product sign = sign1^sign2; quotient sign = sign1^sign2; remainder sign = sign1.
  - Unsigned ops force both flags to 0.
- MUL: WIDTH cycles of shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle, then FIX.
- DIV: WIDTH cycles of restoring division, one quotient bit per cycle, then FIX.
- FIX (1 cycle):
  - Apply two's-complement negation per the sign flags.
  - Write HI/LO at the closing edge:
    - MUL: HI = upper half, LO = lower half.
    - DIV: LO = quotient, HI = remainder.
  - w_done=1 during the following cycle only; state returns to IDLE.
- Latency and overlap:
  - w_busy is high for exactly WIDTH+1 cycles (33 at default) after the accept edge.
  - New HI/LO are visible in the same cycle that w_done is high.
  - A new w_start is acceptable in the w_done cycle.
- Divide by zero (rt=0):
  - Detected at accept; full latency is still taken.
  - Result is HI=rs (original, unnegated), LO=all ones, regardless of signedness.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (falls out of the magnitude method; no trap).
- While w_busy=1:
  - w_start of any opcode, including MTHI/MTLO, is not accepted and w_stall=1. The requester must hold the request until w_stall drops.
  - HI/LO keep their old values until the FIX edge.
- w_hilo_read never modifies state; it only contributes to w_stall.

Test Plan:
- Reset, then MULT rs=7, rt=6: w_busy high 33 cycles, w_done pulses once -> HI=0x00000000, LO=0x0000002A.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Signed and unsigned divides:
  - DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU rs=100, rt=7 -> LO=14, HI=2.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=100, rt=0 -> after 33 cycles HI=0x00000064, LO=0xFFFFFFFF.
- MTHI 0x12345678 while idle -> HI updated after 1 edge, w_busy and w_done stay 0. Start a MULT, then on cycle 5 assert MTLO with w_start plus w_hilo_read -> w_stall=1, LO unchanged until the MULT result is written, MTLO ignored.
- Start DIV, assert reset at busy cycle 10 -> next cycle HI=LO=0, w_busy=0, w_done never pulses. A new MULTU 3*4 then completes normally with LO=12.
